// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;

    // Even parity is the XOR of the data bits; odd parity is its complement.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_tick marks the last clock of each serial bit period.
// tick_next reports whether bit_tick will be high in the following cycle, which
// lets the transmitter register its end-of-frame pulse without a combinational path.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick,
    output logic tick_next
);

    localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;

    assign bit_tick  = (r_count == LAST);
    assign tick_next = (w_count_next == LAST);

    // Wrap at every bit boundary and hold at zero while cleared, so each state starts a fresh period.
    always_comb begin
        w_count_next = r_count + 1'b1;
        if (clear || bit_tick) begin
            w_count_next = '0;
        end
    end

    // Count register, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

endmodule

// File: rtl/transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, parity bit, stop bit.
// A one-entry holding register lets the next byte follow the stop bit with no idle gap.
module transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 data_out,
    output logic                 busy,
    output logic                 done
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    tx_state_t            r_state;
    tx_state_t            w_next_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [2:0]           r_bit_idx;
    logic [2:0]           w_bit_idx_next;
    logic                 r_parity;
    logic                 w_parity_next;
    logic [DATA_BITS-1:0] r_hold;
    logic [DATA_BITS-1:0] w_hold_next;
    logic                 r_hold_valid;
    logic                 w_hold_valid_next;
    logic                 r_data_out;
    logic                 w_data_out_next;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_done_next;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_clear;
    logic                 w_bit_tick;
    logic                 w_tick_next;

    assign w_ready  = enable && !r_hold_valid;
    assign w_accept = tx_valid && w_ready;
    assign tx_ready = rst && w_ready;
    assign w_clear  = (r_state == IDLE);

    assign data_out = r_data_out;
    assign busy     = r_busy;
    assign done     = r_done;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_clear),
        .bit_tick (w_bit_tick),
        .tick_next(w_tick_next)
    );

    // Next-state logic; data_out is computed one cycle ahead so the line is driven straight from a flop.
    always_comb begin
        w_next_state      = r_state;
        w_shift_next      = r_shift;
        w_bit_idx_next    = r_bit_idx;
        w_parity_next     = r_parity;
        w_hold_next       = r_hold;
        w_hold_valid_next = r_hold_valid;
        w_data_out_next   = r_data_out;
        case (r_state)
            IDLE: begin
                w_data_out_next = 1'b1;
                if (r_hold_valid) begin
                    w_shift_next      = r_hold;
                    w_parity_next     = calc_parity(r_hold, PARITY_ODD);
                    w_hold_valid_next = 1'b0;
                    w_next_state      = START;
                    w_data_out_next   = 1'b0;
                end else if (w_accept) begin
                    w_shift_next    = tx_data;
                    w_parity_next   = calc_parity(tx_data, PARITY_ODD);
                    w_next_state    = START;
                    w_data_out_next = 1'b0;
                end
            end
            START: begin
                if (w_bit_tick) begin
                    w_next_state    = DATA;
                    w_bit_idx_next  = '0;
                    w_data_out_next = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_tick) begin
                    if (r_bit_idx == LAST_IDX) begin
                        w_next_state    = PARITY;
                        w_data_out_next = r_parity;
                    end else begin
                        w_shift_next    = r_shift >> 1;
                        w_bit_idx_next  = r_bit_idx + 3'd1;
                        w_data_out_next = r_shift[1];
                    end
                end
            end
            PARITY: begin
                if (w_bit_tick) begin
                    w_next_state    = STOP;
                    w_data_out_next = 1'b1;
                end
            end
            STOP: begin
                if (w_bit_tick) begin
                    if (r_hold_valid) begin
                        w_shift_next      = r_hold;
                        w_parity_next     = calc_parity(r_hold, PARITY_ODD);
                        w_hold_valid_next = 1'b0;
                        w_next_state      = START;
                        w_data_out_next   = 1'b0;
                    end else begin
                        w_next_state    = IDLE;
                        w_data_out_next = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state    = IDLE;
                w_data_out_next = 1'b1;
            end
        endcase
        // Bytes arriving while a frame is in flight park in the holding register.
        // A drain and a capture never coincide because tx_ready is low while hold is full.
        if (w_accept && (r_state != IDLE)) begin
            w_hold_next       = tx_data;
            w_hold_valid_next = 1'b1;
        end
    end

    assign w_done_next = (w_next_state == STOP) && w_tick_next;

    // State and output registers; reset aborts any frame and returns the line to idle-high at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_parity     <= 1'b0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_data_out   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_shift      <= w_shift_next;
            r_bit_idx    <= w_bit_idx_next;
            r_parity     <= w_parity_next;
            r_hold       <= w_hold_next;
            r_hold_valid <= w_hold_valid_next;
            r_data_out   <= w_data_out_next;
            r_busy       <= (w_next_state != IDLE);
            r_done       <= w_done_next;
        end
    end

endmodule
